// File: rtl/alu_control_sequencer.sv
// Registered ALU control decode with a multi-cycle MAC beat sequencer for the
// CONV opcode class; stalls the decode stage while a sequence is in flight.
module alu_control_sequencer #(
  parameter int CTRL_W   = 4,
  parameter int KERNEL_N = 9,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [6:0]        op,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              ctrl_valid_o,
  output logic [CNT_W-1:0]  mac_beat_o,
  output logic              acc_clr_o,
  output logic              acc_done_o,
  output logic              stall_o
);

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_LOAD = 4'b0100;
  localparam logic [3:0] C_SLT  = 4'b0101;
  localparam logic [3:0] C_XOR  = 4'b0110;
  localparam logic [3:0] C_MAC  = 4'b0111;
  localparam logic [3:0] C_SLL  = 4'b1000;
  localparam logic [3:0] C_SRL  = 4'b1001;
  localparam logic [3:0] C_SRA  = 4'b1010;
  localparam logic [3:0] C_SLTU = 4'b1011;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(KERNEL_N - 1);

  if (CTRL_W < 4) begin : g_bad_ctrl_w
    $error("CTRL_W must be at least 4");
  end
  if (KERNEL_N < 1 || KERNEL_N > (2**CNT_W) - 1) begin : g_bad_kernel_n
    $error("KERNEL_N out of range for CNT_W");
  end

  typedef enum logic {ST_IDLE, ST_MAC} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_code;
  logic             is_conv;

  // Only op[5] and funct7[5] take part in the decode.
  logic unused_bits;
  assign unused_bits = ^{op[6], op[4:0], funct7[6], funct7[4:0]};

  always_comb begin
    dec_code = C_ADD;
    is_conv  = 1'b0;
    case (ALUOp)
      2'b00: dec_code = C_ADD;
      2'b01: dec_code = C_SUB;
      2'b11: begin
        if (funct3 == 3'b000) begin
          is_conv  = 1'b1;
          dec_code = C_MAC;
        end else begin
          dec_code = C_LOAD;
        end
      end
      default: begin
        case (funct3)
          3'b000:  dec_code = ({op[5], funct7[5]} == 2'b11) ? C_SUB : C_ADD;
          3'b001:  dec_code = C_SLL;
          3'b010:  dec_code = C_SLT;
          3'b011:  dec_code = C_SLTU;
          3'b100:  dec_code = C_XOR;
          3'b101:  dec_code = funct7[5] ? C_SRA : C_SRL;
          3'b110:  dec_code = C_OR;
          default: dec_code = C_AND;
        endcase
      end
    endcase
  end

  assign stall_o = (state == ST_MAC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      ALUControl   <= '0;
      ctrl_valid_o <= 1'b0;
      mac_beat_o   <= '0;
      acc_clr_o    <= 1'b0;
      acc_done_o   <= 1'b0;
    end else if (flush_i) begin
      // Aborted sequences never raise acc_done_o; ALUControl keeps its value.
      state        <= ST_IDLE;
      cnt          <= '0;
      ctrl_valid_o <= 1'b0;
      mac_beat_o   <= '0;
      acc_clr_o    <= 1'b0;
      acc_done_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          mac_beat_o <= '0;
          if (valid_i) begin
            ALUControl   <= CTRL_W'(dec_code);
            ctrl_valid_o <= 1'b1;
            acc_clr_o    <= is_conv;
            acc_done_o   <= is_conv && (KERNEL_N == 1);
            if (is_conv && (KERNEL_N != 1)) begin
              cnt   <= CNT_W'(1);
              state <= ST_MAC;
            end
          end else begin
            ctrl_valid_o <= 1'b0;
            acc_clr_o    <= 1'b0;
            acc_done_o   <= 1'b0;
          end
        end
        default: begin
          ALUControl   <= CTRL_W'(C_MAC);
          ctrl_valid_o <= 1'b1;
          mac_beat_o   <= cnt;
          acc_clr_o    <= 1'b0;
          if (cnt == LAST_BEAT) begin
            acc_done_o <= 1'b1;
            cnt        <= '0;
            state      <= ST_IDLE;
          end else begin
            acc_done_o <= 1'b0;
            cnt        <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/alu_control_sequencer.md
# alu_control_sequencer

Registered, parametrised successor to the combinational ALU control decode in the RISC-V CNN accelerator's decode/execute boundary. Decodes ALUOp/funct3/funct7/op into a widened ALU control code with the full RV32I register/immediate ALU set. For the CONV opcode class it runs a multi-cycle MAC sequence: it emits KERNEL_N consecutive MAC beats with accumulator clear/done strobes and stalls the upstream stage until the sequence completes.

## Interface
- CTRL_W, 4: ALUControl width; must be ≥4; codes are zero-extended.
- KERNEL_N, 9: MAC beats per CONV instruction; legal range 1..2**CNT_W-1.
- CNT_W, 8: beat counter width.

- clk  in  1  rising-edge clock; one clock only.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  decode stage presents an instruction this cycle.
- ALUOp  in  2  main decoder ALU operation class.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- op  in  7  instruction opcode.
- flush_i  in  1  synchronous abort (branch/hazard flush).
- ALUControl  out  CTRL_W  registered ALU control code.
- ctrl_valid_o  out  1  ALUControl valid this cycle.
- mac_beat_o  out  CNT_W  beat index of the current MAC code; 0 otherwise.
- acc_clr_o  out  1  pulse on MAC beat 0.
- acc_done_o  out  1  pulse on MAC beat KERNEL_N-1.
- stall_o  out  1  combinational; the instruction presented this cycle is not consumed.

## Operation
- Codes: ADD 0000, SUB 0001, AND 0010, OR 0011, LOAD 0100, SLT 0101, XOR 0110, MAC 0111, SLL 1000, SRL 1001, SRA 1010, SLTU 1011. Legacy 3-bit values are unchanged.
- Decode:
  - ALUOp 00 → ADD.
  - ALUOp 01 → SUB.
  - ALUOp 11 with funct3 000 → CONV.
  - ALUOp 11 with any other funct3 → LOAD.
  - ALUOp 10 with funct3 000 → SUB if {op[5],funct7[5]}==11, else ADD.
  - ALUOp 10 with funct3 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR.
  - ALUOp 10 with funct3 101 → SRA if funct7[5], else SRL.
  - ALUOp 10 with funct3 110 → OR; 111 → AND.
- States: IDLE, MAC. Beat counter cnt is CNT_W bits.
- IDLE, valid_i=1, flush_i=0, non-CONV: register the decoded code, ctrl_valid_o=1. State stays IDLE.
- IDLE, valid_i=1, flush_i=0, CONV:
  - Register MAC, mac_beat_o=0, acc_clr_o=1, ctrl_valid_o=1.
  - If KERNEL_N==1: also acc_done_o=1, state stays IDLE.
  - Otherwise: cnt←1, go to MAC.
- MAC:
  - Each cycle register MAC, mac_beat_o=cnt, ctrl_valid_o=1, cnt←cnt+1.
  - When cnt==KERNEL_N-1: acc_done_o=1, cnt←0, go to IDLE.
  - valid_i is ignored in MAC.
- stall_o = (state==MAC). In IDLE stall_o is 0 and the presented instruction is consumed.
- No accept (valid_i=0 in IDLE): ctrl_valid_o, acc_clr_o, acc_done_o and mac_beat_o go to 0; ALUControl holds its last value.
- flush_i has highest priority in every state. Next cycle: state IDLE, cnt 0, ctrl_valid_o/acc_clr_o/acc_done_o/mac_beat_o all 0. The instruction presented with the flush is dropped. No acc_done_o is issued for an aborted sequence.

## Timing
- Reset (rst=0, asynchronous): state IDLE, cnt 0, ALUControl 0, ctrl_valid_o 0, mac_beat_o 0, acc_clr_o 0, acc_done_o 0. stall_o is 0 while in reset.
- Reset release is synchronous to clk. The first accept occurs on the first rising edge with rst=1.
- Latency: outputs appear 1 cycle after accept.
- Non-CONV throughput is 1 instruction/cycle with back-to-back valid outputs.
- CONV accepted at edge t:
  - Beats 0..KERNEL_N-1 are visible in cycles t+1..t+KERNEL_N.
  - stall_o is high in cycles t+1..t+KERNEL_N-1.
  - The next instruction is accepted at t+KERNEL_N; its output appears at t+KERNEL_N+1 with no bubble.
- Reset asserted mid-sequence aborts immediately. No acc_done_o is emitted.
- Counter wrap cannot occur inside the legal KERNEL_N range.

## Test plan
- Reset with rst=0 for 3 cycles, valid_i toggling → all outputs 0, stall_o 0; first instruction after release decodes normally.
- Sweep ALUOp=10 for all funct3 plus funct7[5]/op[5] combinations → every code matches the table, e.g. funct3=000, op=0110011, funct7=0100000 gives 0001. ALUOp=00/01/11 (funct3≠000) give 0000/0001/0100.
- CONV with KERNEL_N=9 followed immediately by ADD:
  - MAC beats 0..8 in cycles t+1..t+9.
  - acc_clr_o at t+1, acc_done_o at t+9.
  - stall_o high t+1..t+8.
  - ADD output at t+10.
- KERNEL_N=1 build: CONV → single MAC beat with acc_clr_o and acc_done_o both 1, stall_o never high.
- flush_i at beat 4 of a 9-beat CONV → next cycle ctrl_valid_o 0, state IDLE, no acc_done_o; a following CONV restarts at beat 0 with acc_clr_o.
- rst asserted at beat 3 → outputs 0 asynchronously; after release a new SUB decodes to 0001 with 1-cycle latency.
